// File: rtl/led_blink_pkg.sv
// Shared types and helpers for the multi-channel LED blink controller.
package led_blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_blink_chan.sv
// One LED channel: mode/half-period state, period counter, blink phase,
// breathe duty ramp, and the registered led/wrap outputs.
// led and wrap are registered from next-state values, so in any cycle they
// reflect the channel state visible in that same cycle.
module led_blink_chan
  import led_blink_pkg::*;
#(
  parameter int CNT_W        = 25,
  parameter int PWM_W        = 8,
  parameter int DEFAULT_HALF = 2**24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  mode_e            cfg_mode,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic [PWM_W-1:0] pwm_nxt,
  output logic             led,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'((DEFAULT_HALF < 1) ? 1 : DEFAULT_HALF);
  localparam logic [PWM_W-1:0] DUTY_ONE = PWM_W'(1);
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

  mode_e            mode, mode_n;
  logic [CNT_W-1:0] half, half_n, cnt, cnt_n;
  logic [PWM_W-1:0] duty, duty_n;
  logic             phase, phase_n, dir_up, dir_up_n;
  logic             hit, led_n, wrap_n;

  assign hit = (cnt == half - ONE);

  // Next state: free-running period counter, phase toggle and duty ramp on
  // wrap; a load overrides everything (including a coincident wrap).
  always_comb begin
    mode_n   = mode;
    half_n   = half;
    cnt_n    = hit ? '0 : cnt + ONE;
    phase_n  = phase ^ hit;
    duty_n   = duty;
    dir_up_n = dir_up;
    if (hit && mode == MODE_BREATHE) begin
      if (dir_up) begin
        duty_n = duty + DUTY_ONE;
        if (duty_n == DUTY_MAX) dir_up_n = 1'b0;
      end else begin
        duty_n = duty - DUTY_ONE;
        if (duty_n == '0) dir_up_n = 1'b1;
      end
    end
    if (load) begin
      mode_n   = cfg_mode;
      half_n   = (cfg_half == '0) ? ONE : cfg_half;
      cnt_n    = '0;
      phase_n  = 1'b0;
      duty_n   = '0;
      dir_up_n = 1'b1;
    end
    wrap_n = (cnt_n == half_n - ONE);
    case (mode_n)
      MODE_OFF:     led_n = 1'b0;
      MODE_ON:      led_n = 1'b1;
      MODE_BLINK:   led_n = phase_n;
      MODE_BREATHE: led_n = (pwm_nxt < duty_n);
      default:      led_n = 1'b0;
    endcase
  end

  // Channel state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode   <= MODE_BLINK;
      half   <= HALF_RST;
      cnt    <= '0;
      phase  <= 1'b0;
      duty   <= '0;
      dir_up <= 1'b1;
      led    <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      mode   <= mode_n;
      half   <= half_n;
      cnt    <= cnt_n;
      phase  <= phase_n;
      duty   <= duty_n;
      dir_up <= dir_up_n;
      led    <= led_n;
      wrap   <= wrap_n;
    end
  end

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED driver top: config handshake, shared PWM counter,
// channel decode and the per-channel instance array.
// Build option LED_DIFF_OUT_EN: replaces led with led_p/led_n driven through
// one OBUFDS per channel; logic and timing are unchanged.
module led_blink_ctrl
  import led_blink_pkg::*;
#(
  parameter  int NUM_CH       = 4,
  parameter  int CNT_W        = 25,
  parameter  int PWM_W        = 8,
  parameter  int DEFAULT_HALF = 2**24,
  localparam int CH_W         = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_half_period,
`ifdef LED_DIFF_OUT_EN
  output logic [NUM_CH-1:0] led_p,
  output logic [NUM_CH-1:0] led_n,
`else
  output logic [NUM_CH-1:0] led,
`endif
  output logic [NUM_CH-1:0] wrap
);

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    mode_e            mode;
    logic [CNT_W-1:0] half;
  } cfg_req_t;

  cfg_req_t          req;
  logic              xfer;
  logic [PWM_W-1:0]  pwm_cnt, pwm_nxt;
  logic [NUM_CH-1:0] load, led_int;

  assign req     = '{ch: cfg_ch, mode: mode_e'(cfg_mode), half: cfg_half_period};
  assign xfer    = cfg_valid && cfg_ready;
  assign pwm_nxt = pwm_cnt + PWM_W'(1);

  // Ready drops for one cycle after each accepted request, then recovers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_ready <= 1'b0;
    else     cfg_ready <= !xfer;
  end

  // Shared free-running PWM counter; config never touches it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_nxt;
  end

  // Out-of-range channel numbers match no instance and are silently dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load[i] = xfer && (req.ch == CH_W'(i));
    led_blink_chan #(
      .CNT_W(CNT_W), .PWM_W(PWM_W), .DEFAULT_HALF(DEFAULT_HALF)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .load    (load[i]),
      .cfg_mode(req.mode),
      .cfg_half(req.half),
      .pwm_nxt (pwm_nxt),
      .led     (led_int[i]),
      .wrap    (wrap[i])
    );
  end

`ifdef LED_DIFF_OUT_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_obuf
    OBUFDS u_obufds (.I(led_int[i]), .O(led_p[i]), .OB(led_n[i]));
  end
`else
  assign led = led_int;
`endif

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl: stimulus pushes per-cycle expectations
// into a queue, a monitor pops and compares on each sample event.
// Channel 2 is never configured; its expected bits follow the default
// 4-cycle blink from the last reset release.
module tb_led_blink_ctrl;

  localparam int NUM_CH = 3, CNT_W = 4, PWM_W = 3, DEFAULT_HALF = 4;

  logic              clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, cfg_ready;
  logic [1:0]        cfg_ch = '0, cfg_mode = '0;
  logic [CNT_W-1:0]  cfg_half_period = '0;
  logic [NUM_CH-1:0] led, wrap;

  typedef struct {
    string      name;
    logic [2:0] led;
    logic [2:0] wrap;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   errors = 0, checks = 0, cyc = 0;
  event smp_ev;

  led_blink_ctrl #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PWM_W(PWM_W), .DEFAULT_HALF(DEFAULT_HALF)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_half_period(cfg_half_period),
    .led(led), .wrap(wrap)
  );

  always #5 clk = ~clk;
  always @(negedge clk) -> smp_ev;

  task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  // Monitor: compare whatever expectation is pending at each sample point.
  initial begin
    exp_t e;
    forever begin
      @(smp_ev);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, " led"},  led,  e.led);
        chk({e.name, " wrap"}, wrap, e.wrap);
        chk({e.name, " rdy"},  {2'b00, cfg_ready}, {2'b00, e.rdy});
      end
    end
  end

  // l/w are {ch1,ch0}; ch2 bits come from the default cadence.
  task automatic expect_now(input string ph, input logic [1:0] l, input logic [1:0] w,
                            input logic r);
    exp_t e;
    e.name = $sformatf("%s@%0d", ph, cyc);
    e.led  = {((cyc / 4) % 2) == 1, l};
    e.wrap = {(cyc % 4) == 3, w};
    e.rdy  = r;
    q.push_back(e);
  endtask

  task automatic step(input string ph, input logic [1:0] l, input logic [1:0] w,
                      input logic r);
    expect_now(ph, l, w, r);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [1:0] m, input logic [3:0] h);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_mode = m; cfg_half_period = h;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:23] brth;
    exp_t        r;
    brth = 24'b011111110111000001111110;

    // reset state
    r.name = "reset"; r.led = 3'b000; r.wrap = 3'b000; r.rdy = 1'b0;
    q.push_back(r);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; cyc = 0;

    // default blink, no config
    for (int k = 0; k < 12; k++)
      step("dflt", ((k / 4) % 2 == 1) ? 2'b11 : 2'b00, (k % 4 == 3) ? 2'b11 : 2'b00, k != 0);

    // back-to-back: ch1 ON then ch0 OFF with valid held
    cfg(1, 2'b01, 4); step("b2b", 2'b11, 2'b00, 1'b1);
    cfg(0, 2'b00, 4); step("b2b", 2'b11, 2'b00, 1'b0);
    step("b2b", 2'b11, 2'b00, 1'b1);
    cfg_valid = 1'b0;
    step("b2b", 2'b10, 2'b00, 1'b0);
    step("b2b", 2'b10, 2'b10, 1'b1);
    step("b2b", 2'b10, 2'b00, 1'b1);
    step("b2b", 2'b10, 2'b01, 1'b1);
    step("b2b", 2'b10, 2'b00, 1'b1);
    step("b2b", 2'b10, 2'b10, 1'b1);
    step("b2b", 2'b10, 2'b00, 1'b1);

    // ch0 BLINK half=0 issued on ch0's wrap cycle
    cfg(0, 2'b10, 0); step("half0", 2'b10, 2'b01, 1'b1);
    cfg_valid = 1'b0;
    step("half0", 2'b10, 2'b01, 1'b0);
    step("half0", 2'b11, 2'b11, 1'b1);
    step("half0", 2'b10, 2'b01, 1'b1);
    step("half0", 2'b11, 2'b01, 1'b1);
    step("half0", 2'b10, 2'b01, 1'b1);
    step("half0", 2'b11, 2'b11, 1'b1);
    step("half0", 2'b10, 2'b01, 1'b1);

    // ch0 BREATHE half=1: duty 0,1..7,6..0,1..7,6,5 against pwm = cycle mod 8
    cfg(0, 2'b11, 1); step("brth", 2'b11, 2'b01, 1'b1);
    cfg_valid = 1'b0;
    for (int j = 0; j < 24; j++)
      step("brth", {1'b1, brth[j]}, {(cyc % 4) == 0, 1'b1}, j != 0);

    // out-of-range channel: handshake only
    cfg(3, 2'b01, 5); step("badch", 2'b10, 2'b01, 1'b1);
    cfg_valid = 1'b0;
    step("badch", 2'b11, 2'b11, 1'b0);
    step("badch", 2'b11, 2'b01, 1'b1);
    step("badch", 2'b10, 2'b01, 1'b1);

    // line ch0/ch1 up in BLINK so all leds are high together
    cfg(0, 2'b10, 5); step("align", 2'b10, 2'b01, 1'b1);
    cfg_valid = 1'b0;
    step("align", 2'b10, 2'b10, 1'b0);
    cfg(1, 2'b10, 4); step("align", 2'b10, 2'b00, 1'b1);
    cfg_valid = 1'b0;
    step("align", 2'b00, 2'b00, 1'b0);
    step("align", 2'b00, 2'b00, 1'b1);
    step("align", 2'b00, 2'b01, 1'b1);
    step("align", 2'b01, 2'b10, 1'b1);
    step("align", 2'b11, 2'b00, 1'b1);
    step("align", 2'b11, 2'b00, 1'b1);
    step("align", 2'b11, 2'b00, 1'b1);

    // async reset mid-cycle while all leds are on
    expect_now("prerst", 2'b11, 2'b11, 1'b1);
    @(negedge clk); #1;
    rst = 1'b1; #1;
    r.name = "rst_async"; r.led = 3'b000; r.wrap = 3'b000; r.rdy = 1'b0;
    q.push_back(r);
    -> smp_ev;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; cyc = 0;
    for (int k = 0; k < 9; k++)
      step("restart", ((k / 4) % 2 == 1) ? 2'b11 : 2'b00, (k % 4 == 3) ? 2'b11 : 2'b00, k != 0);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
